// File: rtl/usb_rx_phy_if.sv
// Pad-side and packet-decoder-side signals of the full-speed USB receive front end.
// The slave modport is the PHY; the master modport drives the pads and consumes bytes.
interface usb_rx_phy_if;
   logic       dp_raw;
   logic       dn_raw;
   logic       tx_en;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_active;
   logic       rx_eop;
   logic       rx_err;
   logic       usb_rst;

   modport master (
      output dp_raw, dn_raw, tx_en,
      input  rx_data, rx_valid, rx_active, rx_eop, rx_err, usb_rst
   );

   modport slave (
      input  dp_raw, dn_raw, tx_en,
      output rx_data, rx_valid, rx_active, rx_eop, rx_err, usb_rst
   );
endinterface

// File: rtl/usb_rx_phy.sv
// Full-speed USB receiver: 4x oversampling DPLL, NRZI decode, SYNC hunt, bit unstuffing,
// EOP detection and bus-reset detection, delivering LSB-first bytes with one-cycle strobes.
module usb_rx_phy #(
   parameter int RESET_CYCLES   = 120,
   parameter int SYNC_MIN_ZEROS = 3
) (
   input  logic         clk48,
   input  logic         rst,
   usb_rx_phy_if.slave  bus
);

   localparam logic [1:0] LS_J   = 2'b10;
   localparam logic [1:0] LS_K   = 2'b01;
   localparam logic [1:0] LS_SE0 = 2'b00;
   localparam logic [1:0] LS_SE1 = 2'b11;

   localparam int               RST_W   = $clog2(RESET_CYCLES + 1);
   localparam logic [RST_W-1:0] RST_MAX = RST_W'(RESET_CYCLES);
   localparam logic [RST_W-1:0] RST_ONE = RST_W'(1);
   localparam logic [3:0]       SYNC_MIN = 4'(SYNC_MIN_ZEROS);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SYNC,
      S_DATA,
      S_EOP1,
      S_EOP2,
      S_WAITJ
   } state_e;

   // Synchroniser and line-change detection
   logic [1:0]       sync1_q;
   logic [1:0]       line_q;
   logic [1:0]       line_prev_q;
   logic [1:0]       phase_q, phase_d;
   logic             line_change;
   logic             sample;

   // Decoder state
   state_e           state_q, state_d;
   logic [1:0]       prev_state_q, prev_state_d;
   logic [3:0]       zeros_q, zeros_d;
   logic [2:0]       ones_q, ones_d;
   logic [2:0]       bit_cnt_q, bit_cnt_d;
   logic [7:0]       shift_q, shift_d;
   logic             j_seen_q, j_seen_d;

   // Outputs and bus-reset detection
   logic [7:0]       rx_data_q, rx_data_d;
   logic             rx_valid_q, rx_valid_d;
   logic             rx_active_q, rx_active_d;
   logic             rx_eop_q, rx_eop_d;
   logic             rx_err_q, rx_err_d;
   logic [RST_W-1:0] se0_cnt_q, se0_cnt_d;

   logic             is_j, is_k, is_se0, is_se1;
   logic             nrzi_bit;

   // Synchroniser resets to idle J so release from reset never looks like a K edge.
   always_ff @(posedge clk48 or negedge rst) begin
      if (!rst) begin
         sync1_q     <= LS_J;
         line_q      <= LS_J;
         line_prev_q <= LS_J;
      end else begin
         sync1_q     <= {bus.dp_raw, bus.dn_raw};
         line_q      <= sync1_q;
         line_prev_q <= line_q;
      end
   end

   // The cycle on which a new line state first appears is phase 0, so the sample lands
   // two cycles into each bit and tolerates both short (3) and long (5) bit cells.
   assign line_change = (line_q != line_prev_q);
   assign phase_d     = line_change ? 2'd0 : phase_q + 2'd1;
   assign sample      = (phase_d == 2'd2);

   assign is_j     = (line_q == LS_J);
   assign is_k     = (line_q == LS_K);
   assign is_se0   = (line_q == LS_SE0);
   assign is_se1   = (line_q == LS_SE1);
   assign nrzi_bit = (line_q == prev_state_q);

   // NOTE: every signal driven here gets a default first, so no path leaves one unassigned
   // and no latch is inferred.
   always_comb begin
      state_d      = state_q;
      prev_state_d = prev_state_q;
      zeros_d      = zeros_q;
      ones_d       = ones_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      j_seen_d     = j_seen_q;
      rx_data_d    = rx_data_q;
      rx_valid_d   = 1'b0;
      rx_eop_d     = 1'b0;
      rx_err_d     = 1'b0;

      if (sample) begin
         prev_state_d = line_q;
         unique case (state_q)
            S_IDLE: begin
               if (is_k) begin
                  state_d = S_SYNC;
                  zeros_d = 4'd1;
               end
            end

            S_SYNC: begin
               if (is_se1) begin
                  rx_err_d = 1'b1;
                  state_d  = S_WAITJ;
               end else if (is_se0) begin
                  state_d = S_IDLE;
               end else if (!nrzi_bit) begin
                  if (zeros_q != 4'hF) zeros_d = zeros_q + 4'd1;
               end else if (zeros_q >= SYNC_MIN) begin
                  // The terminating 1 of SYNC does not count towards the stuffing run.
                  state_d   = S_DATA;
                  ones_d    = 3'd0;
                  bit_cnt_d = 3'd0;
               end else begin
                  state_d = S_IDLE;
               end
            end

            S_DATA: begin
               if (is_se1) begin
                  rx_err_d = 1'b1;
                  state_d  = S_WAITJ;
               end else if (is_se0) begin
                  state_d = S_EOP1;
               end else if (ones_q == 3'd6) begin
                  if (nrzi_bit) begin
                     rx_err_d = 1'b1;
                     state_d  = S_WAITJ;
                  end else begin
                     ones_d = 3'd0;
                  end
               end else begin
                  shift_d   = {nrzi_bit, shift_q[7:1]};
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  ones_d    = nrzi_bit ? ones_q + 3'd1 : 3'd0;
                  if (bit_cnt_q == 3'd7) begin
                     rx_data_d  = shift_d;
                     rx_valid_d = 1'b1;
                  end
               end
            end

            S_EOP1: begin
               if (is_se0) begin
                  state_d = S_EOP2;
               end else begin
                  rx_err_d = 1'b1;
                  state_d  = S_WAITJ;
               end
            end

            // Any partially shifted byte is simply abandoned here.
            S_EOP2: begin
               if (is_j) begin
                  rx_eop_d = 1'b1;
                  state_d  = S_IDLE;
               end else if (!is_se0) begin
                  rx_err_d = 1'b1;
                  state_d  = S_WAITJ;
               end
            end

            S_WAITJ: begin
               if (is_j) begin
                  if (j_seen_q) begin
                     state_d  = S_IDLE;
                     j_seen_d = 1'b0;
                  end else begin
                     j_seen_d = 1'b1;
                  end
               end else begin
                  j_seen_d = 1'b0;
               end
            end

            default: state_d = S_IDLE;
         endcase
      end

      // Our own transmitter owns the line: blank everything and re-qualify idle afterwards.
      if (bus.tx_en) begin
         state_d    = S_WAITJ;
         j_seen_d   = 1'b0;
         rx_data_d  = rx_data_q;
         rx_valid_d = 1'b0;
         rx_eop_d   = 1'b0;
         rx_err_d   = 1'b0;
      end
   end

   assign rx_active_d = (state_d == S_DATA) || (state_d == S_EOP1) || (state_d == S_EOP2);

   // Bus reset watches the line only; it ignores the decoder and tx_en.
   always_comb begin
      se0_cnt_d = '0;
      if (is_se0) begin
         se0_cnt_d = (se0_cnt_q == RST_MAX) ? se0_cnt_q : se0_cnt_q + RST_ONE;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // the pre-edge values, regardless of block ordering.
   always_ff @(posedge clk48 or negedge rst) begin
      if (!rst) begin
         phase_q      <= 2'd0;
         state_q      <= S_IDLE;
         prev_state_q <= LS_J;
         zeros_q      <= 4'd0;
         ones_q       <= 3'd0;
         bit_cnt_q    <= 3'd0;
         shift_q      <= 8'h00;
         j_seen_q     <= 1'b0;
         rx_data_q    <= 8'h00;
         rx_valid_q   <= 1'b0;
         rx_active_q  <= 1'b0;
         rx_eop_q     <= 1'b0;
         rx_err_q     <= 1'b0;
         se0_cnt_q    <= '0;
      end else begin
         phase_q      <= phase_d;
         state_q      <= state_d;
         prev_state_q <= prev_state_d;
         zeros_q      <= zeros_d;
         ones_q       <= ones_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         j_seen_q     <= j_seen_d;
         rx_data_q    <= rx_data_d;
         rx_valid_q   <= rx_valid_d;
         rx_active_q  <= rx_active_d;
         rx_eop_q     <= rx_eop_d;
         rx_err_q     <= rx_err_d;
         se0_cnt_q    <= se0_cnt_d;
      end
   end

   assign bus.rx_data   = rx_data_q;
   assign bus.rx_valid  = rx_valid_q;
   assign bus.rx_active = rx_active_q;
   assign bus.rx_eop    = rx_eop_q;
   assign bus.rx_err    = rx_err_q;
   assign bus.usb_rst   = (se0_cnt_q == RST_MAX);

endmodule

// File: doc/usb_rx_phy.md
Name: usb_rx_phy

Overview:
Full-speed USB receive front end for the 48 MHz USB device core, sitting between the D+/D- input pads and the packet decoder that feeds usb_annunciator's transaction logic. Oversamples the line 4x, recovers bit timing with a simple DPLL, and performs NRZI decoding, SYNC detection, bit unstuffing and EOP detection. Delivers LSB-first bytes with a one-cycle strobe. Also produces the bus-reset indication (usb_rst).

Parameters:
RESET_CYCLES, 120, clk48 cycles of continuous SE0 before usb_rst asserts (2.5 us)
SYNC_MIN_ZEROS, 3, minimum decoded 0 bits before the terminating 1 of SYNC

Ports:
clk48  input  1  48 MHz clock
rst  input  1  asynchronous reset, active-low; clears all state
dp_raw  input  1  D+ pad, asynchronous to clk48
dn_raw  input  1  D- pad, asynchronous to clk48
tx_en  input  1  transmitter driving bus; receiver blanked while high
rx_data  output  8  last completed byte
rx_valid  output  1  one-cycle strobe, rx_data valid
rx_active  output  1  high from SYNC completion to EOP/abort
rx_eop  output  1  one-cycle strobe on valid end of packet
rx_err  output  1  one-cycle strobe on stuff error or SE1
usb_rst  output  1  bus reset detected

Behaviour:
- Reset values: rx_data=0, rx_valid=0, rx_active=0, rx_eop=0, rx_err=0, usb_rst=0. FSM=IDLE. DPLL phase=0. prev_state=J.
- Input path: 2-FF synchroniser on dp_raw/dn_raw. All logic below uses the synchronised pair.
- Line states: J=(1,0), K=(0,1), SE0=(0,0), SE1=(1,1).
- DPLL: 2-bit phase counter, free-running mod 4. Reset to 0 on every change of the synchronised line state. Sample point is phase==2.
- NRZI: at each sample, bit=1 if the sampled J/K equals prev_state, else 0. prev_state is updated on every sample.
- FSM states:
  - IDLE: wait for a K sample, then go to SYNC (zero count=1).
  - SYNC: each 0 increments the zero count. A 1 with count>=SYNC_MIN_ZEROS goes to DATA and sets rx_active the next cycle. A 1 with count<SYNC_MIN_ZEROS goes to IDLE, no strobes.
  - DATA: shift bits LSB-first into an 8-bit shifter. On the 8th bit, rx_data/rx_valid update on the cycle after the sample point.
  - Bit unstuff: ones counter clears on a 0. After 6 consecutive 1s, the next bit is dropped when it is 0. If it is 1: pulse rx_err, clear rx_active, go to WAITJ. The counter carries across byte boundaries.
  - EOP: SE0 on two consecutive sample points, followed by a J sample. Then pulse rx_eop, clear rx_active, go to IDLE. A partial byte (bit count 1..7) is discarded silently (dribble).
  - SE1 at any sample in SYNC/DATA: pulse rx_err, go to WAITJ.
  - WAITJ: remain until the line has been J on 2 consecutive samples, then go to IDLE.
- rx_valid and rx_eop never assert in the same cycle. rx_eop never follows an rx_err within the same packet.
- tx_en=1: FSM forced to WAITJ, rx_active cleared, no strobes. Receive resumes after tx_en falls and the J condition is met.
- usb_rst: a counter increments every cycle the synchronised line is SE0 and saturates at RESET_CYCLES; any non-SE0 sample clears it. usb_rst=1 while the counter equals RESET_CYCLES, and falls the cycle after the first non-SE0 sample. It is independent of tx_en and the FSM.
- Reset mid-packet: all outputs clear immediately (asynchronous). After release the FSM starts in IDLE with prev_state=J.

Test Plan:
- Each bit is driven for 4 clk48 cycles. Send SYNC (KJKJKJKK), byte 0x69, EOP (SE0,SE0,J) -> rx_active rises after SYNC; exactly one rx_valid with rx_data=0x69; one rx_eop; rx_err stays 0; rx_active falls with rx_eop.
- Send SYNC, 0xFF, 0xFF with stuffed zeros inserted after each run of six 1s, then EOP -> two rx_valid, both 0xFF; no rx_err.
- Send SYNC, then seven NRZI 1s with no stuffed zero -> one rx_err pulse; rx_active=0; no rx_valid; no rx_eop; next clean packet received correctly.
- Hold SE0 for 119 cycles, then J -> usb_rst stays 0. Hold SE0 for 130 cycles -> usb_rst rises 120 cycles after the first synchronised SE0, and falls within 4 cycles of J returning.
- tx_en=1 for the whole of a 0x69 packet -> no rx_active, rx_valid or rx_eop. Drop tx_en, idle J, resend -> 0x69 received.
- Bit periods alternating 3 and 5 cycles for packet 0xC3 -> rx_data=0xC3 with no error. Assert rst low mid-byte -> all outputs 0 immediately; a packet sent after release decodes correctly.
